ysyx_23060061_lsu_axil: RTL and testbench

Parametrised load/store unit between EXU and WBU in the multi-cycle NPC core. It accepts one memory request at a time over a valid/ready handshake and performs it as a single AXI4-Lite transaction with byte-lane alignment and result extension. AW and W are handshaked independently. Misaligned accesses and bus error responses are reported to WBU as an access fault. Non-memory instructions pass straight through.

---
 rtl/ysyx_23060061_pkg.sv | 27 ++
 rtl/ysyx_23060061_lsu_align.sv | 62 ++++++
 rtl/ysyx_23060061_lsu_axil.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_23060061_lsu_axil.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060061_pkg.sv
// Shared encodings for the NPC load/store path: FSM states, access sizes, AXI response codes.
package ysyx_23060061_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AR   = 3'd1;
    localparam state_t ST_R    = 3'd2;
    localparam state_t ST_AWW  = 3'd3;
    localparam state_t ST_B    = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Any non-OKAY response is reported to WBU as an access fault.
    function automatic logic resp_fault(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_23060061_lsu_align.sv
// Byte-lane alignment for the LSU: store strobe/data placement, load shift/extension,
// and the natural-alignment check on incoming requests.
module ysyx_23060061_lsu_align
    import ysyx_23060061_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned SW = XLEN / 8,
    localparam int unsigned OB = $clog2(SW)
) (
    input  logic [1:0]      req_size,
    input  logic [OB-1:0]   req_off,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      ld_size,
    input  logic            ld_unsigned,
    input  logic [OB-1:0]   ld_off,
    input  logic [XLEN-1:0] ld_raw,
    output logic            misalign_c,
    output logic [SW-1:0]   wstrb_c,
    output logic [XLEN-1:0] wdata_c,
    output logic [XLEN-1:0] rdata_c
);

    logic [SW-1:0]   mask;
    logic [XLEN-1:0] shifted;

    // Request side: lane mask, lane placement, alignment (dword is illegal on a 32-bit bus).
    always_comb begin
        misalign_c = 1'b0;
        mask       = '1;
        case (req_size)
            SIZE_B: mask = SW'(1);
            SIZE_H: begin
                mask       = SW'(3);
                misalign_c = req_off[0];
            end
            SIZE_W: begin
                mask       = SW'(15);
                misalign_c = |req_off[1:0];
            end
            SIZE_D: begin
                mask       = '1;
                misalign_c = (XLEN < 64) || (|req_off);
            end
            default: ;
        endcase
        wstrb_c = mask << req_off;
        wdata_c = req_wdata << {req_off, 3'b000};
    end

    // Response side: bring the addressed lanes down to bit 0 and extend.
    always_comb begin
        shifted = ld_raw >> {ld_off, 3'b000};
        rdata_c = shifted;
        case (ld_size)
            SIZE_B: rdata_c = ld_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            SIZE_H: rdata_c = ld_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            SIZE_W: rdata_c = ld_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060061_lsu_axil.sv
// Load/store unit between EXU and WBU: one request at a time, performed as a single
// AXI4-Lite transaction; non-memory instructions bypass straight to WBU.
module ysyx_23060061_lsu_axil
    import ysyx_23060061_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_rd,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [AW-1:0]     in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_fault,
    output logic [AW-1:0]     araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [XLEN-1:0]   rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [AW-1:0]     awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int unsigned SW = XLEN / 8;
    localparam int unsigned OB = $clog2(SW);

    state_t          state, state_n;
    logic            mem_req, bypass, accept;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [OB-1:0]   ld_off;
    logic            aw_done, w_done, aw_fin, w_fin;
    logic            misalign_c;
    logic [SW-1:0]   wstrb_c;
    logic [XLEN-1:0] wdata_c, rdata_c;
    logic [AW-1:0]   addr_al;

    assign mem_req = in_rd | in_wr;
    assign bypass  = in_valid & ~mem_req;
    assign accept  = (state == ST_IDLE) && in_valid && mem_req;
    assign aw_fin  = aw_done | (awvalid & awready);
    assign w_fin   = w_done  | (wvalid & wready);
    assign addr_al = {in_addr[AW-1:OB], OB'(0)};

    ysyx_23060061_lsu_align #(.XLEN(XLEN)) u_align (
        .req_size    (in_size),
        .req_off     (in_addr[OB-1:0]),
        .req_wdata   (in_wdata),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_off      (ld_off),
        .ld_raw      (rdata),
        .misalign_c  (misalign_c),
        .wstrb_c     (wstrb_c),
        .wdata_c     (wdata_c),
        .rdata_c     (rdata_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = misalign_c ? ST_DONE : (in_rd ? ST_AR : ST_AWW);
            ST_AR:   if (arready) state_n = ST_R;
            ST_R:    if (rvalid) state_n = ST_DONE;
            ST_AWW:  if (aw_fin && w_fin) state_n = ST_B;
            ST_B:    if (bvalid) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Handshake outputs toward EXU/WBU; the bypass path is purely combinational.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                out_valid = bypass;
                in_ready  = bypass ? out_ready : 1'b1;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // AXI channel registers and the WBU result; every AXI-facing control is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            ld_size     <= '0;
            ld_unsigned <= 1'b0;
            ld_off      <= '0;
            out_rdata   <= '0;
            out_fault   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    ld_size     <= in_size;
                    ld_unsigned <= in_unsigned;
                    ld_off      <= in_addr[OB-1:0];
                    out_rdata   <= '0;
                    if (misalign_c) begin
                        out_fault <= 1'b1;
                    end else if (in_rd) begin
                        araddr  <= addr_al;
                        arvalid <= 1'b1;
                    end else begin
                        awaddr  <= addr_al;
                        wdata   <= wdata_c;
                        wstrb   <= wstrb_c;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ST_AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
                ST_R: if (rvalid) begin
                    rready    <= 1'b0;
                    out_fault <= resp_fault(rresp);
                    out_rdata <= resp_fault(rresp) ? '0 : rdata_c;
                end
                ST_AWW: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    aw_done <= aw_fin;
                    w_done  <= w_fin;
                    if (aw_fin && w_fin) bready <= 1'b1;
                end
                ST_B: if (bvalid) begin
                    bready    <= 1'b0;
                    out_fault <= resp_fault(bresp);
                    out_rdata <= '0;
                end
                ST_DONE: if (out_ready) begin
                    out_rdata <= '0;
                    out_fault <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_lsu_axil.sv
// Directed bench for the LSU: 32-bit and 64-bit instances driven cycle by cycle
// against hand-computed AXI payloads and WBU results.
module tb_ysyx_23060061_lsu_axil;
    import ysyx_23060061_pkg::*;

    logic clk, rst;

    logic        in_valid, in_ready, in_rd, in_wr, in_unsigned;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    logic        d_in_valid, d_in_ready, d_in_rd, d_in_wr, d_in_unsigned;
    logic [1:0]  d_in_size;
    logic [31:0] d_in_addr;
    logic [63:0] d_in_wdata;
    logic        d_out_valid, d_out_ready, d_out_fault;
    logic [63:0] d_out_rdata;
    logic [31:0] d_araddr, d_awaddr;
    logic [63:0] d_rdata, d_wdata;
    logic        d_arvalid, d_arready, d_rvalid, d_rready, d_awvalid, d_awready;
    logic        d_wvalid, d_wready, d_bvalid, d_bready;
    logic [1:0]  d_rresp, d_bresp;
    logic [7:0]  d_wstrb;

    int nvec = 0;
    int nerr = 0;

    ysyx_23060061_lsu_axil #(.XLEN(32), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_wr(in_wr),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_fault(out_fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    ysyx_23060061_lsu_axil #(.XLEN(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_rd(d_in_rd), .in_wr(d_in_wr),
        .in_size(d_in_size), .in_unsigned(d_in_unsigned), .in_addr(d_in_addr), .in_wdata(d_in_wdata),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rdata(d_out_rdata), .out_fault(d_out_fault),
        .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
        .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready),
        .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
        .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
        .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load on the 32-bit unit; checks N+1 AR, N+2 R, N+3 result, then a held DONE.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rd, input logic [1:0] resp,
                           input logic [31:0] exp_rd, input logic exp_f);
        in_valid = 1'b1; in_rd = 1'b1; in_wr = 1'b0; in_size = size;
        in_unsigned = uns; in_addr = addr; arready = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_rd = 1'b0;
        chk($sformatf("%s arvalid", tag), 64'(arvalid), 64'd1);
        chk($sformatf("%s araddr", tag), 64'(araddr), 64'({addr[31:2], 2'b00}));
        tick();
        chk($sformatf("%s rready", tag), 64'(rready), 64'd1);
        chk($sformatf("%s early out_valid", tag), 64'(out_valid), 64'd0);
        rvalid = 1'b1; rdata = rd; rresp = resp;
        tick();
        rvalid = 1'b0; rdata = 32'h0; rresp = RESP_OKAY;
        chk($sformatf("%s out_valid", tag), 64'(out_valid), 64'd1);
        chk($sformatf("%s out_rdata", tag), 64'(out_rdata), 64'(exp_rd));
        chk($sformatf("%s out_fault", tag), 64'(out_fault), 64'(exp_f));
        tick();
        chk($sformatf("%s held out_valid", tag), 64'(out_valid), 64'd1);
        chk($sformatf("%s held out_rdata", tag), 64'(out_rdata), 64'(exp_rd));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("%s release", tag), 64'(out_valid), 64'd0);
    endtask

    // Zero-wait store with AW and W accepted together.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input logic [1:0] resp,
                            input logic [31:0] exp_wd, input logic [3:0] exp_st, input logic exp_f);
        in_valid = 1'b1; in_rd = 1'b0; in_wr = 1'b1; in_size = size; in_addr = addr;
        in_wdata = wd; awready = 1'b1; wready = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_wr = 1'b0;
        chk($sformatf("%s awvalid", tag), 64'(awvalid), 64'd1);
        chk($sformatf("%s wvalid", tag), 64'(wvalid), 64'd1);
        chk($sformatf("%s awaddr", tag), 64'(awaddr), 64'({addr[31:2], 2'b00}));
        chk($sformatf("%s wdata", tag), 64'(wdata), 64'(exp_wd));
        chk($sformatf("%s wstrb", tag), 64'(wstrb), 64'(exp_st));
        tick();
        chk($sformatf("%s bready", tag), 64'(bready), 64'd1);
        chk($sformatf("%s aw/w dropped", tag), 64'({awvalid, wvalid}), 64'd0);
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = RESP_OKAY;
        chk($sformatf("%s out_valid", tag), 64'(out_valid), 64'd1);
        chk($sformatf("%s out_fault", tag), 64'(out_fault), 64'(exp_f));
        chk($sformatf("%s out_rdata", tag), 64'(out_rdata), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Request rejected by alignment: one-cycle fault, no bus traffic.
    task automatic do_misalign(input string tag, input logic rd, input logic wr,
                               input logic [1:0] size, input logic [31:0] addr);
        in_valid = 1'b1; in_rd = rd; in_wr = wr; in_size = size; in_addr = addr; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
        chk($sformatf("%s no bus", tag), 64'({arvalid, awvalid, wvalid}), 64'd0);
        chk($sformatf("%s out_valid", tag), 64'(out_valid), 64'd1);
        chk($sformatf("%s out_fault", tag), 64'(out_fault), 64'd1);
        chk($sformatf("%s out_rdata", tag), 64'(out_rdata), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("%s release", tag), 64'(out_valid), 64'd0);
    endtask

    task automatic do_load64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [63:0] rd, input logic [63:0] exp_rd);
        d_in_valid = 1'b1; d_in_rd = 1'b1; d_in_wr = 1'b0; d_in_size = size;
        d_in_unsigned = uns; d_in_addr = addr; d_arready = 1'b1; d_out_ready = 1'b0;
        tick();
        d_in_valid = 1'b0; d_in_rd = 1'b0;
        chk($sformatf("%s araddr", tag), 64'(d_araddr), 64'({addr[31:3], 3'b000}));
        tick();
        d_rvalid = 1'b1; d_rdata = rd; d_rresp = RESP_OKAY;
        tick();
        d_rvalid = 1'b0;
        chk($sformatf("%s out_valid", tag), 64'(d_out_valid), 64'd1);
        chk($sformatf("%s out_rdata", tag), d_out_rdata, exp_rd);
        chk($sformatf("%s out_fault", tag), 64'(d_out_fault), 64'd0);
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
    endtask

    task automatic do_store64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                              input logic [63:0] wd, input logic [63:0] exp_wd, input logic [7:0] exp_st);
        d_in_valid = 1'b1; d_in_rd = 1'b0; d_in_wr = 1'b1; d_in_size = size; d_in_addr = addr;
        d_in_wdata = wd; d_awready = 1'b1; d_wready = 1'b1; d_out_ready = 1'b0;
        tick();
        d_in_valid = 1'b0; d_in_wr = 1'b0;
        chk($sformatf("%s wdata", tag), d_wdata, exp_wd);
        chk($sformatf("%s wstrb", tag), 64'(d_wstrb), 64'(exp_st));
        tick();
        d_bvalid = 1'b1; d_bresp = RESP_OKAY;
        tick();
        d_bvalid = 1'b0;
        chk($sformatf("%s out_valid", tag), 64'(d_out_valid), 64'd1);
        d_out_ready = 1'b1;
        tick();
        d_out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        {in_valid, in_rd, in_wr, in_unsigned, out_ready} = '0;
        in_size = 2'd0; in_addr = 32'h0; in_wdata = 32'h0;
        {arready, rvalid, awready, wready, bvalid} = '0;
        rdata = 32'h0; rresp = RESP_OKAY; bresp = RESP_OKAY;
        {d_in_valid, d_in_rd, d_in_wr, d_in_unsigned, d_out_ready} = '0;
        d_in_size = 2'd0; d_in_addr = 32'h0; d_in_wdata = 64'h0;
        {d_arready, d_rvalid, d_awready, d_wready, d_bvalid} = '0;
        d_rdata = 64'h0; d_rresp = RESP_OKAY; d_bresp = RESP_OKAY;
        tick();
        tick();

        chk("rst valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("rst out", 64'({out_valid, out_fault}), 64'd0);
        chk("rst out_rdata", 64'(out_rdata), 64'd0);
        chk("rst payload", 64'({araddr, wdata}), 64'd0);
        chk("rst wstrb", 64'(wstrb), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst64 valids", 64'({d_arvalid, d_awvalid, d_wvalid, d_rready, d_bready}), 64'd0);
        rst = 1'b1;
        tick();

        do_load("lb_s", 32'h8000_0003, SIZE_B, 1'b0, 32'h80FF_FF12, RESP_OKAY, 32'hFFFF_FF80, 1'b0);
        do_load("lbu", 32'h8000_0003, SIZE_B, 1'b1, 32'h80FF_FF12, RESP_OKAY, 32'h0000_0080, 1'b0);
        do_load("lh_s", 32'h8000_0002, SIZE_H, 1'b0, 32'h80FF_FF12, RESP_OKAY, 32'hFFFF_80FF, 1'b0);
        do_load("lhu0", 32'h8000_0000, SIZE_H, 1'b1, 32'h80FF_FF12, RESP_OKAY, 32'h0000_FF12, 1'b0);
        do_load("lw", 32'h8000_0004, SIZE_W, 1'b0, 32'h1234_5678, RESP_OKAY, 32'h1234_5678, 1'b0);
        do_load("lw_slverr", 32'h8000_0004, SIZE_W, 1'b0, 32'h1234_5678, RESP_SLVERR, 32'h0, 1'b1);
        do_load("lb_decerr", 32'h8000_0001, SIZE_B, 1'b0, 32'hFFFF_FFFF, RESP_DECERR, 32'h0, 1'b1);

        do_store("sb", 32'h8000_0001, SIZE_B, 32'h0000_00A5, RESP_OKAY, 32'h0000_A500, 4'b0010, 1'b0);
        do_store("sw_decerr", 32'h8000_0000, SIZE_W, 32'hCAFE_F00D, RESP_DECERR, 32'hCAFE_F00D, 4'b1111, 1'b1);

        // Half store with AW accepted at N+1 and W only at N+4.
        in_valid = 1'b1; in_wr = 1'b1; in_size = SIZE_H; in_addr = 32'h8000_0002;
        in_wdata = 32'h0000_ABCD; awready = 1'b1; wready = 1'b0;
        tick();
        in_valid = 1'b0; in_wr = 1'b0;
        chk("skew wstrb", 64'(wstrb), 64'h0000_000C);
        chk("skew wdata", 64'(wdata), 64'h0000_0000_ABCD_0000);
        tick();
        awready = 1'b0;
        chk("skew aw dropped", 64'({awvalid, wvalid}), 64'b01);
        tick();
        chk("skew w held", 64'({wvalid, bready}), 64'b10);
        chk("skew wdata held", 64'(wdata), 64'h0000_0000_ABCD_0000);
        tick();
        wready = 1'b1;
        chk("skew no early B", 64'(bready), 64'd0);
        tick();
        wready = 1'b0;
        chk("skew in B", 64'({wvalid, bready, out_valid}), 64'b010);
        bvalid = 1'b1; bresp = RESP_OKAY;
        tick();
        bvalid = 1'b0;
        chk("skew done", 64'({out_valid, out_fault}), 64'b10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        do_misalign("lw_mis", 1'b1, 1'b0, SIZE_W, 32'h8000_0006);
        do_misalign("sh_mis", 1'b0, 1'b1, SIZE_H, 32'h8000_0001);
        do_misalign("ld_x32", 1'b1, 1'b0, SIZE_D, 32'h8000_0000);

        // Bypass: out_valid follows in_valid, in_ready follows out_ready.
        in_valid = 1'b1; in_rd = 1'b0; in_wr = 1'b0; out_ready = 1'b1;
        #1;
        chk("byp valid", 64'({out_valid, in_ready}), 64'b11);
        out_ready = 1'b0;
        #1;
        chk("byp stall", 64'({out_valid, in_ready}), 64'b10);
        tick();
        chk("byp no bus", 64'({arvalid, awvalid, wvalid, out_valid}), 64'b0001);
        in_valid = 1'b0;
        #1;
        chk("byp idle", 64'({out_valid, in_ready}), 64'b01);

        // Reset while waiting in R aborts the load.
        in_valid = 1'b1; in_rd = 1'b1; in_size = SIZE_W; in_addr = 32'h8000_0010; arready = 1'b1;
        tick();
        in_valid = 1'b0; in_rd = 1'b0;
        tick();
        chk("abort in R", 64'(rready), 64'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("abort idle", 64'({out_valid, in_ready}), 64'b01);
        do_load("after_rst", 32'h8000_0002, SIZE_H, 1'b1, 32'hBEEF_1234, RESP_OKAY, 32'h0000_BEEF, 1'b0);

        do_load64("ld64", 32'h8000_0008, SIZE_D, 1'b1, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
        do_load64("lw64", 32'h8000_000C, SIZE_W, 1'b0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
        do_store64("sd64", 32'h8000_0008, SIZE_D, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
        do_store64("sb64", 32'h8000_0007, SIZE_B, 64'h0000_0000_0000_005A, 64'h5A00_0000_0000_0000, 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
